// File: rtl/q_pattern_detector_pkg.sv
// Shared types and default constants for the q-stream blocks.
// The default pattern constants are also used by the upstream stage's bench.
package q_stream_pkg;

  localparam int             DEF_PATTERN_W = 4;
  localparam logic [3:0]     DEF_PATTERN   = 4'b1011;
  localparam int             DEF_CNT_W     = 8;

  // FILL: window still collecting fresh samples; ARMED: every sample can hit.
  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } q_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky saturation flag.
// The flag rises in the same cycle the count reaches all-ones and holds until rst or clr.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             sat_d, sat_q;

  // Next count: clear wins, otherwise increment unless already all-ones.
  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (clr) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else begin
      if (inc && !(&cnt_q)) begin
        cnt_d = cnt_q + 1'b1;
      end
      sat_d = sat_q | (&cnt_d);
    end
  end

  // Count and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule

// File: rtl/q_pattern_detector.sv
// Serial pattern detector for the registered q bit stream.
// Shifts enabled samples into a window, pulses match one cycle after a sample
// completes PATTERN, and keeps a saturating hit count.
// Handshake: there is no back-pressure; a sample is taken on every clock edge
// where en=1 and clear=0, and match is a registered one-cycle strobe.
module q_pattern_detector
  import q_stream_pkg::*;
#(
  parameter int                   PATTERN_W = DEF_PATTERN_W,
  parameter logic [PATTERN_W-1:0] PATTERN   = PATTERN_W'(DEF_PATTERN),
  parameter int                   CNT_W     = DEF_CNT_W,
  parameter bit                   OVERLAP   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 q_in,
  input  logic                 clear,
  output logic                 match,
  output logic [CNT_W-1:0]     match_cnt,
  output logic                 cnt_sat,
  output logic [PATTERN_W-1:0] hist,
  output logic                 armed
);

  localparam int                FILL_W    = $clog2(PATTERN_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PATTERN_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PATTERN_W - 1);

  logic [PATTERN_W-1:0] hist_d, hist_q;
  logic [FILL_W-1:0]    fill_d, fill_q;
  q_state_e             state_d, state_q;
  logic                 match_d, match_q;
  logic [PATTERN_W-1:0] cand;
  logic                 hit;

  // Window update, fill tracking and FILL/ARMED transitions.
  always_comb begin
    cand    = {hist_q[PATTERN_W-2:0], q_in};
    hit     = en && !clear && (cand == PATTERN) &&
              ((state_q == ARMED) || (fill_q == FILL_LAST));
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    match_d = hit;
    if (clear) begin
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else if (en) begin
      hist_d = cand;
      if (hit && !OVERLAP) begin
        // Non-overlapping: the hit consumes the window, refill from scratch.
        fill_d  = '0;
        state_d = FILL;
      end else begin
        if (fill_q != FILL_FULL) begin
          fill_d = fill_q + 1'b1;
        end
        if (fill_q >= FILL_LAST) begin
          state_d = ARMED;
        end
      end
    end
  end

  // Detector state registers; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q  <= '0;
      fill_q  <= '0;
      state_q <= FILL;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      match_q <= match_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_hit_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clear),
    .inc (hit),
    .cnt (match_cnt),
    .sat (cnt_sat)
  );

  assign match = match_q;
  assign hist  = hist_q;
  assign armed = (state_q == ARMED);

endmodule

// File: tb/tb_q_pattern_detector.sv
// Bench for q_pattern_detector: three instances (default, non-overlapping,
// 2-bit counter) share one input stream and are compared every cycle against
// a sample-history reference model.
module tb_q_pattern_detector;

  localparam int         PW  = 4;
  localparam logic [3:0] PAT = 4'b1011;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, en = 1'b0, q_in = 1'b0, clear = 1'b0;

  logic       m0, m1, m2, s0, s1, s2, a0, a1, a2;
  logic [7:0] c0, c1;
  logic [1:0] c2;
  logic [3:0] h0, h1, h2;

  q_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .CNT_W(8), .OVERLAP(1'b1)) dut_ov (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in), .clear(clear),
    .match(m0), .match_cnt(c0), .cnt_sat(s0), .hist(h0), .armed(a0));

  q_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .CNT_W(8), .OVERLAP(1'b0)) dut_no (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in), .clear(clear),
    .match(m1), .match_cnt(c1), .cnt_sat(s1), .hist(h1), .armed(a1));

  q_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .CNT_W(2), .OVERLAP(1'b1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .q_in(q_in), .clear(clear),
    .match(m2), .match_cnt(c2), .cnt_sat(s2), .hist(h2), .armed(a2));

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Model keeps the raw samples since the last clear plus, per instance, how
  // many fresh samples have arrived since clear or (non-overlapping) last hit.
  logic     samp_q[$];
  int       fresh[3];
  int       cnt_m[3];
  bit       exp_match[3];
  const bit ovl[3]  = '{1'b1, 1'b0, 1'b1};
  const int cmax[3] = '{255, 255, 3};

  function automatic logic [3:0] window();
    logic [3:0] w = '0;
    foreach (samp_q[k]) w = {w[2:0], samp_q[k]};
    return w;
  endfunction

  task automatic model_update(input logic e, input logic q, input logic c, input logic r);
    for (int i = 0; i < 3; i++) exp_match[i] = 1'b0;
    if (r || c) begin
      samp_q.delete();
      for (int i = 0; i < 3; i++) begin
        fresh[i] = 0;
        cnt_m[i] = 0;
      end
    end else if (e) begin
      samp_q.push_back(q);
      if (samp_q.size() > PW) void'(samp_q.pop_front());
      for (int i = 0; i < 3; i++) begin
        if (fresh[i] < PW) fresh[i]++;
        if (fresh[i] >= PW && window() == PAT) begin
          exp_match[i] = 1'b1;
          if (cnt_m[i] < cmax[i]) cnt_m[i]++;
          if (!ovl[i]) fresh[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all();
    logic got_m[3], got_s[3], got_a[3];
    int   got_c[3];
    logic [3:0] got_h[3];
    got_m = '{m0, m1, m2};
    got_s = '{s0, s1, s2};
    got_a = '{a0, a1, a2};
    got_c = '{int'(c0), int'(c1), int'(c2)};
    got_h = '{h0, h1, h2};
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("match%0d", i), got_m[i], exp_match[i]);
      chk($sformatf("cnt%0d", i), got_c[i], cnt_m[i]);
      chk($sformatf("sat%0d", i), got_s[i], (cnt_m[i] == cmax[i]) ? 1 : 0);
      chk($sformatf("hist%0d", i), got_h[i], window());
      chk($sformatf("armed%0d", i), got_a[i], (fresh[i] >= PW) ? 1 : 0);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic e, input logic q, input logic c, input logic r);
    en = e; q_in = q; clear = c; rst = r;
    @(posedge clk);
    model_update(e, q, c, r);
    #1;
    check_all();
  endtask

  task automatic feed(input logic [15:0] bits, input int n);
    for (int k = n - 1; k >= 0; k--) step(1'b1, bits[k], 1'b0, 1'b0);
  endtask

  task automatic do_clear();
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b0, 1'b1);

    // Basic hit.
    feed(16'b1011, 4);
    chk("basic_match", m0, 1);
    chk("basic_cnt", c0, 1);

    // Overlapping stream, then the non-overlap streams.
    do_clear();
    feed(16'b1011011, 7);
    chk("ovl_cnt", c0, 2);
    chk("novl_cnt", c1, 1);
    do_clear();
    feed(16'b10110111, 8);
    chk("novl_ext_cnt", c1, 1);
    do_clear();
    feed(16'b10111011, 8);
    chk("novl_two_cnt", c1, 2);

    // Enable gaps with q_in toggling while idle.
    do_clear();
    for (int k = 3; k >= 0; k--) begin
      logic [3:0] p = PAT;
      step(1'b1, p[k], 1'b0, 1'b0);
      for (int g = 0; g < 3; g++) step(1'b0, g[0], 1'b0, 1'b0);
    end
    chk("gap_cnt", c0, 1);

    // Saturation of the 2-bit counter.
    do_clear();
    feed(16'b1011, 4);
    for (int r = 0; r < 4; r++) feed(16'b011, 3);
    chk("sat_cnt", c2, 3);
    chk("sat_flag", s2, 1);
    do_clear();
    chk("sat_clr_cnt", c2, 0);
    chk("sat_clr_flag", s2, 0);

    // Reset mid-fill with a completing-looking sample.
    feed(16'b101, 3);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    chk("rst_mid_match", m0, 0);
    chk("rst_mid_hist", h0, 0);
    feed(16'b1011, 4);
    chk("after_rst_cnt", c0, 1);

    // Clear coinciding with a completing sample.
    do_clear();
    feed(16'b101, 3);
    step(1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_hit_match", m0, 0);

    // Random stream.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 199) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 199) < 1) ? 1'b1 : 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
